twos_accum: RTL and testbench

- Sequential stage directly downstream of the team's 4-bit two's-complement negator.
- Accepts a frame of NUM_SAMPLES signed 4-bit samples over a valid/ready handshake.
- Sign-extends each sample and accumulates it with saturation, then presents the frame sum and an overflow flag on an output valid/ready handshake.
- Used to sum negated operands, so subtraction is done by negate-then-accumulate.

---
 rtl/twos_accum_if.sv | 24 ++
 rtl/twos_accum.sv | 114 +++++++++++
 tb/tb_twos_accum.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/twos_accum_if.sv
// Sample-in / frame-sum-out handshake bundle for the saturating frame accumulator.
// The master side is the upstream/downstream environment, the slave side is the accumulator.
interface twos_accum_if #(
  parameter int DIN_W = 4,
  parameter int ACC_W = 8
);
  logic [DIN_W-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             ovf;

  modport master (
    output din, din_valid, sum_ready,
    input  din_ready, sum, sum_valid, ovf
  );

  modport slave (
    input  din, din_valid, sum_ready,
    output din_ready, sum, sum_valid, ovf
  );
endinterface

// File: rtl/twos_accum.sv
// Saturating accumulator of NUM_SAMPLES signed samples per frame, with a sticky
// per-frame overflow flag and valid/ready handshakes on both sides.
module twos_accum #(
  parameter int DIN_W       = 4,
  parameter int ACC_W       = 8,
  parameter int NUM_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  twos_accum_if.slave bus
);

  localparam logic [0:0]       ST_ACC   = 1'b0;
  localparam logic [0:0]       ST_DONE  = 1'b1;
  localparam logic [3:0]       LAST_IDX = 4'(NUM_SAMPLES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  // Returns {saturated, result}; the sum is formed one bit wider so the two top
  // bits disagreeing is exactly the out-of-range condition.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [DIN_W-1:0] d);
    logic [ACC_W:0] ext;
    logic [ACC_W:0] t;
    logic [ACC_W:0] r;
    ext = {{(ACC_W+1-DIN_W){d[DIN_W-1]}}, d};
    t   = {a[ACC_W-1], a} + ext;
    case ({t[ACC_W], t[ACC_W-1]})
      2'b01:   r = {1'b1, ACC_MAX};
      2'b10:   r = {1'b1, ACC_MIN};
      default: r = {1'b0, t[ACC_W-1:0]};
    endcase
    return r;
  endfunction

  logic [0:0]       state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [3:0]       cnt_r, cnt_s;
  logic             ovf_r, ovf_s;
  logic             din_ready_r, din_ready_s;
  logic             sum_valid_r, sum_valid_s;
  logic             accept_s;
  logic [ACC_W:0]   add_s;

  assign accept_s = bus.din_valid && din_ready_r;
  assign add_s    = sat_add(acc_r, bus.din);

  // Next-state, accumulation and handshake-output decode.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    case (state_r)
      ST_ACC: begin
        if (accept_s) begin
          acc_s = add_s[ACC_W-1:0];
          ovf_s = ovf_r | add_s[ACC_W];
          cnt_s = cnt_r + 4'd1;
          if (cnt_r == LAST_IDX) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (bus.sum_ready) begin
          state_s = ST_ACC;
          acc_s   = {ACC_W{1'b0}};
          cnt_s   = 4'd0;
          ovf_s   = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_ACC;
        acc_s   = {ACC_W{1'b0}};
        cnt_s   = 4'd0;
        ovf_s   = 1'b0;
      end
    endcase
    din_ready_s = (state_s == ST_ACC);
    sum_valid_s = (state_s == ST_DONE);
  end

  // State and output registers; din_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACC;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= 4'd0;
      ovf_r       <= 1'b0;
      din_ready_r <= 1'b0;
      sum_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      din_ready_r <= din_ready_s;
      sum_valid_r <= sum_valid_s;
    end
  end

  assign bus.din_ready = din_ready_r;
  assign bus.sum       = acc_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_twos_accum.sv
// Directed bench for twos_accum: an 8-bit and a 5-bit accumulator share one stimulus
// stream and are compared every cycle against an integer-arithmetic frame model.
module tb_twos_accum;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] din;
  logic       din_valid;
  logic       sum_ready;

  twos_accum_if #(.DIN_W(4), .ACC_W(8)) i8 ();
  twos_accum_if #(.DIN_W(4), .ACC_W(5)) i5 ();

  assign i8.din = din;  assign i8.din_valid = din_valid;  assign i8.sum_ready = sum_ready;
  assign i5.din = din;  assign i5.din_valid = din_valid;  assign i5.sum_ready = sum_ready;

  twos_accum #(.DIN_W(4), .ACC_W(8), .NUM_SAMPLES(NS)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  twos_accum #(.DIN_W(4), .ACC_W(5), .NUM_SAMPLES(NS)) u5 (.clk(clk), .rst_n(rst_n), .bus(i5));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int t, input int w);
    int mx;
    int mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    if (t > mx) return mx;
    else if (t < mn) return mn;
    else return t;
  endfunction

  // Frame model: plain integers, clamped to the accumulator range.
  int m_acc8, m_acc5, m_cnt;
  bit m_ovf8, m_ovf5, m_live, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc8 <= 0; m_acc5 <= 0; m_cnt <= 0;
      m_ovf8 <= 1'b0; m_ovf5 <= 1'b0; m_live <= 1'b0; m_done <= 1'b0;
    end else if (!m_live) begin
      m_live <= 1'b1;
    end else if (!m_done) begin
      if (din_valid) begin
        m_acc8 <= clampv(m_acc8 + int'($signed(din)), 8);
        m_acc5 <= clampv(m_acc5 + int'($signed(din)), 5);
        m_ovf8 <= m_ovf8 | (clampv(m_acc8 + int'($signed(din)), 8) != m_acc8 + int'($signed(din)));
        m_ovf5 <= m_ovf5 | (clampv(m_acc5 + int'($signed(din)), 5) != m_acc5 + int'($signed(din)));
        m_cnt  <= m_cnt + 1;
        if (m_cnt + 1 == NS) m_done <= 1'b1;
      end
    end else if (sum_ready) begin
      m_acc8 <= 0; m_acc5 <= 0; m_cnt <= 0;
      m_ovf8 <= 1'b0; m_ovf5 <= 1'b0; m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("din_ready8", i8.din_ready, int'(m_live && !m_done));
    chk("din_ready5", i5.din_ready, int'(m_live && !m_done));
    chk("sum_valid8", i8.sum_valid, int'(m_done));
    chk("sum_valid5", i5.sum_valid, int'(m_done));
    chk("sum8", int'($signed(i8.sum)), m_acc8);
    chk("sum5", int'($signed(i5.sum)), m_acc5);
    chk("ovf8", i8.ovf, int'(m_ovf8));
    chk("ovf5", i5.ovf, int'(m_ovf5));
  end

  task automatic send(input logic [3:0] d, input int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    din = d;
    din_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (i8.din_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] s, input int gap, input int e8, input int e5,
                       input int o8, input int o5, input bit rel);
    for (int i = 0; i < NS; i++) send(s[4*i +: 4], gap);
    chk("latency_sv", i8.sum_valid, 1);
    chk("frame_sum8", int'($signed(i8.sum)), e8);
    chk("frame_sum5", int'($signed(i5.sum)), e5);
    chk("frame_ovf8", i8.ovf, o8);
    chk("frame_ovf5", i5.ovf, o5);
    chk("done_not_ready", i8.din_ready, 0);
    if (rel) begin
      sum_ready = 1'b1;
      @(posedge clk);
      #1;
      sum_ready = 1'b0;
      chk("rel_ready", i8.din_ready, 1);
      chk("rel_sv", i8.sum_valid, 0);
      chk("rel_sum", int'(i8.sum), 0);
    end
  endtask

  initial begin
    din = 4'd0; din_valid = 1'b0; sum_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sum", int'(i8.sum), 0);
    chk("rst_sv", i8.sum_valid, 0);
    chk("rst_ready", i8.din_ready, 0);
    chk("rst_ovf", i8.ovf, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", i8.din_ready, 1);

    // -1 x4 back to back
    frame(16'hFFFF, 0, -4, -4, 0, 0, 1'b1);

    // sum_ready in ACC is ignored
    sum_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 sum_ready = 1'b0;
    chk("acc_sr_ready", i8.din_ready, 1);
    chk("acc_sr_sum", int'(i8.sum), 0);

    // 7, -8, 3, -2 with gaps
    frame(16'hE387, 2, 0, 0, 0, 0, 1'b1);
    // 7 x3 then -8: 5-bit saturates at 15 then lands on 7
    frame(16'h8777, 0, 13, 7, 0, 1, 1'b1);
    // -8 x4: 5-bit pinned at -16
    frame(16'h8888, 1, -32, -16, 0, 1, 1'b0);

    // backpressure with din_valid held high
    din = 4'b0001;
    din_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_sum8", int'($signed(i8.sum)), -32);
      chk("bp_sum5", int'($signed(i5.sum)), -16);
      chk("bp_sv", i8.sum_valid, 1);
      chk("bp_ovf5", i5.ovf, 1);
    end
    din_valid = 1'b0;
    sum_ready = 1'b1;
    @(posedge clk);
    #1 sum_ready = 1'b0;
    chk("bp_rel_ready", i8.din_ready, 1);
    chk("bp_rel_sum5", int'(i5.sum), 0);
    chk("bp_rel_ovf5", i5.ovf, 0);

    // reset mid-frame after two samples
    send(4'b0001, 0);
    send(4'b0001, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum8", int'(i8.sum), 0);
    chk("mid_rst_sum5", int'(i5.sum), 0);
    chk("mid_rst_ready", i8.din_ready, 0);
    chk("mid_rst_sv", i8.sum_valid, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    frame(16'h1111, 0, 4, 4, 0, 0, 1'b1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
